// File: rtl/shadow_pkg.sv
// Shared constants for the shadow capture dump controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package shadow_pkg;

  localparam int BYTE_W = 8;
  localparam int BIT_CW = $clog2(BYTE_W);

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_CAPTURE = 3'd1;
  localparam state_t ST_SELECT  = 3'd2;
  localparam state_t ST_DUMP    = 3'd3;
  localparam state_t ST_FLUSH   = 3'd4;
  localparam state_t ST_DONE    = 3'd5;

endpackage

// File: rtl/shadow_byte_packer.sv
// Packs serial chain bits LSB-first into bytes held in a one-deep output register.
// Latency: byte presented the cycle after its eighth bit (or a flush request).
// Backpressure: room drops while a byte is pending; it clears only when out_rdy takes it.
module shadow_byte_packer
  import shadow_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              bit_in,
  input  logic              shift_last,
  input  logic              flush,
  input  logic              out_rdy,
  output logic              room,
  output logic              loading,
  output logic [BIT_CW-1:0] bit_cnt,
  output logic              byte_vld,
  output logic [BYTE_W-1:0] byte_dat,
  output logic              byte_last
);

  logic [BYTE_W-1:0] sr;
  logic [BYTE_W-1:0] sr_nxt;
  logic              complete;

  // A new bit is only accepted while no byte is waiting, so the output
  // register never needs to hold more than one byte.
  assign room     = !byte_vld;
  assign complete = shift_en && (bit_cnt == BIT_CW'(BYTE_W - 1));
  assign loading  = complete || flush;

  // Insert the incoming bit at the next free position of the shift register.
  always_comb begin
    sr_nxt = sr;
    if (shift_en) begin
      sr_nxt[bit_cnt] = bit_in;
    end
  end

  // Accumulate bits; a completed or flushed byte empties the register, leaving zeros as padding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (clr || loading) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      sr      <= sr_nxt;
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Output byte register: loaded on completion or flush, held until out_rdy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_vld  <= 1'b0;
      byte_dat  <= '0;
      byte_last <= 1'b0;
    end else if (loading) begin
      byte_vld  <= 1'b1;
      byte_dat  <= sr_nxt;
      byte_last <= flush || shift_last;
    end else if (out_rdy) begin
      byte_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/shadow_dump_ctrl.sv
// Arms shadow capture, then dumps each unmasked chain serially as byte packets.
// Latency: a byte appears one cycle after its eighth bit; flush bytes appear one cycle after FLUSH entry.
// Backpressure: out_rdy low holds the byte stable and drops dump_en, pausing the selected chain.
module shadow_dump_ctrl
  import shadow_pkg::*;
#(
  parameter  int NUM_CHAINS = 4,
  parameter  int TIMEOUT    = 255,
  localparam int CW         = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1
) (
  input  logic                  sh_clk,
  input  logic                  sh_rst_n,
  input  logic                  arm,
  input  logic                  freeze,
  input  logic [NUM_CHAINS-1:0] chain_mask,
  output logic                  c_en,
  output logic [NUM_CHAINS-1:0] dump_en,
  input  logic [NUM_CHAINS-1:0] ch_out,
  input  logic [NUM_CHAINS-1:0] ch_out_vld,
  input  logic [NUM_CHAINS-1:0] ch_out_done,
  output logic [BYTE_W-1:0]     out_data,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic                  out_last,
  output logic [CW-1:0]         out_chain,
  output logic                  busy,
  output logic                  err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t                state;
  logic [NUM_CHAINS-1:0] mask_q;
  logic [CW-1:0]         sel;
  logic [CW:0]           next_idx;
  logic [TW-1:0]         idle_cnt;
  logic                  fl_done;

  logic                  found;
  logic [CW-1:0]         pick;
  logic                  room;
  logic                  loading;
  logic [BIT_CW-1:0]     bit_cnt;
  logic                  dump_act;
  logic                  sel_vld;
  logic                  sel_done;
  logic                  shift_en;
  logic                  flush_go;
  logic                  timeout_hit;

  assign c_en        = (state == ST_CAPTURE);
  assign busy        = (state != ST_IDLE);
  assign sel_vld     = ch_out_vld[sel];
  assign sel_done    = ch_out_done[sel];
  assign dump_act    = (state == ST_DUMP) && room;
  assign shift_en    = dump_act && sel_vld;
  assign flush_go    = (state == ST_FLUSH) && !out_vld && !fl_done;
  assign timeout_hit = dump_act && !sel_vld && !sel_done && (idle_cnt == TW'(TIMEOUT - 1));

  // Only the selected chain is enabled, and only while the packer can take a bit.
  always_comb begin
    dump_en = '0;
    if (dump_act) begin
      dump_en[sel] = 1'b1;
    end
  end

  // Lowest masked-in chain at or above the resume index.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = NUM_CHAINS - 1; i >= 0; i--) begin
      if (mask_q[i] && ((CW + 1)'(i) >= next_idx)) begin
        found = 1'b1;
        pick  = CW'(i);
      end
    end
  end

  shadow_byte_packer u_packer (
    .clk        (sh_clk),
    .rst_n      (sh_rst_n),
    .clr        (state == ST_SELECT),
    .shift_en   (shift_en),
    .bit_in     (ch_out[sel]),
    .shift_last (sel_done),
    .flush      (flush_go),
    .out_rdy    (out_rdy),
    .room       (room),
    .loading    (loading),
    .bit_cnt    (bit_cnt),
    .byte_vld   (out_vld),
    .byte_dat   (out_data),
    .byte_last  (out_last)
  );

  // Tag each byte with the chain it came from when it is loaded.
  always_ff @(posedge sh_clk or negedge sh_rst_n) begin
    if (!sh_rst_n) begin
      out_chain <= '0;
    end else if (loading) begin
      out_chain <= sel;
    end
  end

  // Sequence control: capture, then select/dump/flush each chain, then done.
  always_ff @(posedge sh_clk or negedge sh_rst_n) begin
    if (!sh_rst_n) begin
      state    <= ST_IDLE;
      mask_q   <= '0;
      sel      <= '0;
      next_idx <= '0;
      idle_cnt <= '0;
      fl_done  <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arm) begin
            err   <= 1'b0;
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (freeze) begin
            mask_q   <= chain_mask;
            next_idx <= '0;
            state    <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (found) begin
            sel      <= pick;
            next_idx <= (CW + 1)'(pick) + 1'b1;
            idle_cnt <= '0;
            state    <= ST_DUMP;
          end else begin
            state    <= ST_DONE;
          end
        end
        ST_DUMP: begin
          if (dump_act) begin
            if (sel_done) begin
              // A last bit that exactly fills a byte already closes the chain.
              fl_done <= shift_en && (bit_cnt == BIT_CW'(BYTE_W - 1));
              state   <= ST_FLUSH;
            end else if (sel_vld) begin
              idle_cnt <= '0;
            end else if (timeout_hit) begin
              err     <= 1'b1;
              fl_done <= 1'b0;
              state   <= ST_FLUSH;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          // Emit the closing byte, then wait for it to drain before moving on.
          if (!out_vld) begin
            if (fl_done) begin
              state <= ST_SELECT;
            end else begin
              fl_done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shadow_dump_ctrl.sv
// Directed bench for shadow_dump_ctrl with a behavioural chain model and byte log.
// Latency: n/a.
// Backpressure: out_rdy driven by the directed sequence.
module tb_shadow_dump_ctrl;

  logic       sh_clk;
  logic       sh_rst_n;
  logic       arm;
  logic       freeze;
  logic [3:0] chain_mask;
  logic       c_en;
  logic [3:0] dump_en;
  logic [3:0] ch_out;
  logic [3:0] ch_out_vld;
  logic [3:0] ch_out_done;
  logic [7:0] out_data;
  logic       out_vld;
  logic       out_rdy;
  logic       out_last;
  logic [1:0] out_chain;
  logic       busy;
  logic       err;

  int checks   = 0;
  int failures = 0;

  // chain model state
  int          nbits [4];
  int          ptr   [4];
  logic [31:0] pat   [4];
  logic [3:0]  silent;
  logic [3:0]  presented;
  logic [3:0]  noise;

  // byte log
  logic [7:0] q_dat  [$];
  logic       q_last [$];
  logic [1:0] q_ch   [$];

  shadow_dump_ctrl #(.NUM_CHAINS(4), .TIMEOUT(255)) dut (
    .sh_clk      (sh_clk),
    .sh_rst_n    (sh_rst_n),
    .arm         (arm),
    .freeze      (freeze),
    .chain_mask  (chain_mask),
    .c_en        (c_en),
    .dump_en     (dump_en),
    .ch_out      (ch_out),
    .ch_out_vld  (ch_out_vld),
    .ch_out_done (ch_out_done),
    .out_data    (out_data),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .out_last    (out_last),
    .out_chain   (out_chain),
    .busy        (busy),
    .err         (err)
  );

  initial begin
    sh_clk = 1'b0;
    forever #5 sh_clk = ~sh_clk;
  end

  // Chain model: present the next bit while enabled; done rides on the last bit.
  initial begin
    logic [3:0] vld_m, dat_m, done_m;
    forever begin
      @(negedge sh_clk);
      vld_m  = '0;
      dat_m  = '0;
      done_m = '0;
      for (int i = 0; i < 4; i++) begin
        if (presented[i]) ptr[i]++;
        presented[i] = 1'b0;
        if (dump_en[i] && !silent[i]) begin
          if (ptr[i] < nbits[i]) begin
            vld_m[i]     = 1'b1;
            dat_m[i]     = pat[i][ptr[i]];
            done_m[i]    = (ptr[i] == nbits[i] - 1);
            presented[i] = 1'b1;
          end else if (ptr[i] == nbits[i]) begin
            done_m[i] = 1'b1;
          end
        end
      end
      ch_out      = dat_m;
      ch_out_vld  = vld_m | noise;
      ch_out_done = done_m | noise;
    end
  end

  // Byte log: a transfer happens at the next rising edge when both are high.
  initial begin
    forever begin
      @(negedge sh_clk);
      if (sh_rst_n && out_vld && out_rdy) begin
        q_dat.push_back(out_data);
        q_last.push_back(out_last);
        q_ch.push_back(out_chain);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_byte(input int idx, input logic [7:0] d, input logic l, input logic [1:0] c);
    logic [31:0] obs;
    if (idx < q_dat.size()) obs = {21'd0, q_ch[idx], q_last[idx], q_dat[idx]};
    else                    obs = 32'hFFFF_FFFF;
    chk($sformatf("byte%0d{ch,last,dat}", idx), obs, {21'd0, c, l, d});
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge sh_clk);
      #1;
    end
  endtask

  task automatic pulse(input logic a, input logic f);
    arm    = a;
    freeze = f;
    @(posedge sh_clk);
    #1;
    arm    = 1'b0;
    freeze = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int n;
    n = 0;
    while (busy && n < maxc) begin
      @(posedge sh_clk);
      #1;
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic load(input int i, input int n, input logic [31:0] p, input logic s);
    nbits[i]     = n;
    pat[i]       = p;
    silent[i]    = s;
    ptr[i]       = 0;
    presented[i] = 1'b0;
  endtask

  task automatic clear_log();
    q_dat.delete();
    q_last.delete();
    q_ch.delete();
  endtask

  initial begin
    int n;
    sh_rst_n   = 1'b0;
    arm        = 1'b0;
    freeze     = 1'b0;
    chain_mask = '0;
    out_rdy    = 1'b1;
    noise      = '0;
    silent     = '0;
    presented  = '0;
    ch_out      = '0;
    ch_out_vld  = '0;
    ch_out_done = '0;
    for (int i = 0; i < 4; i++) load(i, 0, 32'd0, 1'b0);

    // reset state
    #12;
    chk("reset_outs", 32'({c_en, dump_en, out_vld, out_data, out_last, out_chain, busy, err}), 32'd0);
    @(posedge sh_clk);
    #1;
    sh_rst_n = 1'b1;
    step(2);

    // freeze in IDLE is ignored
    pulse(1'b0, 1'b1);
    step(1);
    chk("idle_freeze_busy", 32'(busy), 32'd0);

    // four chains of 3, 8, 10, 0 bits; garbage above nbits must not leak
    load(0, 3, 32'hFFFF_FFF5, 1'b0);
    load(1, 8, 32'h0000_004D, 1'b0);
    load(2, 10, 32'hFFFF_FF0F, 1'b0);
    load(3, 0, 32'hFFFF_FFFF, 1'b0);
    chain_mask = 4'b1111;
    clear_log();
    pulse(1'b1, 1'b0);
    chk("capture_cen_busy", 32'({c_en, busy, err, dump_en}), 32'b1100_000);
    pulse(1'b0, 1'b1);
    chk("freeze_cen_off", 32'({c_en, busy}), 32'b01);
    wait_idle("basic_done", 400);
    chk("basic_nbytes", 32'(q_dat.size()), 32'd5);
    chk_byte(0, 8'h05, 1'b1, 2'd0);
    chk_byte(1, 8'h4D, 1'b1, 2'd1);
    chk_byte(2, 8'h0F, 1'b0, 2'd2);
    chk_byte(3, 8'h03, 1'b1, 2'd2);
    chk_byte(4, 8'h00, 1'b1, 2'd3);
    step(2);

    // 24-bit chain with a 20-cycle output stall after the first byte
    load(1, 24, 32'h0081_3CA5, 1'b0);
    chain_mask = 4'b0010;
    clear_log();
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    n = 0;
    while (!out_vld && n < 100) begin
      step(1);
      n++;
    end
    chk("stall_first_vld", 32'(out_vld), 32'd1);
    out_rdy = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      chk($sformatf("stall_hold%0d", k),
          32'({dump_en, out_vld, out_last, out_chain, out_data}),
          32'({4'b0000, 1'b1, 1'b0, 2'd1, 8'hA5}));
    end
    out_rdy = 1'b1;
    wait_idle("stall_done", 200);
    chk("stall_nbytes", 32'(q_dat.size()), 32'd3);
    chk_byte(0, 8'hA5, 1'b0, 2'd1);
    chk_byte(1, 8'h3C, 1'b0, 2'd1);
    chk_byte(2, 8'h81, 1'b1, 2'd1);
    step(2);

    // silent chain 2 times out; noise on unselected chain 3 must be ignored
    load(0, 3, 32'h0000_0005, 1'b0);
    load(2, 0, 32'h0, 1'b1);
    noise      = 4'b1000;
    chain_mask = 4'b0101;
    clear_log();
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    n = 0;
    while (!dump_en[2] && n < 100) begin
      step(1);
      n++;
    end
    chk("to_chain2_enabled", 32'(dump_en), 32'b0100);
    n = 0;
    while (!err && n < 400) begin
      step(1);
      n++;
    end
    chk("to_cycles", 32'(n), 32'd255);
    chk("to_err", 32'(err), 32'd1);
    wait_idle("to_done", 100);
    noise = '0;
    chk("to_nbytes", 32'(q_dat.size()), 32'd2);
    chk_byte(0, 8'h05, 1'b1, 2'd0);
    chk_byte(1, 8'h00, 1'b1, 2'd2);
    chk("to_err_sticky", 32'({err, busy}), 32'b10);
    silent[2] = 1'b0;
    step(2);

    // arm and freeze together in IDLE: capture only, err cleared
    clear_log();
    pulse(1'b1, 1'b1);
    chk("af_capture", 32'({c_en, busy, err}), 32'b110);
    step(5);
    pulse(1'b1, 1'b0);
    chk("af_hold", 32'({c_en, dump_en}), 32'b1_0000);
    chain_mask = 4'b0000;
    pulse(1'b0, 1'b1);
    chk("af_freeze_cen", 32'(c_en), 32'd0);
    wait_idle("zero_mask_done", 20);
    chk("zero_mask_nbytes", 32'(q_dat.size()), 32'd0);
    step(2);

    // reset while a byte is pending mid-dump, then a fresh dump from chain 0
    load(1, 24, 32'h0081_3CA5, 1'b0);
    chain_mask = 4'b0010;
    out_rdy    = 1'b0;
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    n = 0;
    while (!out_vld && n < 100) begin
      step(1);
      n++;
    end
    step(2);
    sh_rst_n = 1'b0;
    #1;
    chk("midreset_outs", 32'({c_en, dump_en, out_vld, out_data, out_last, out_chain, busy, err}), 32'd0);
    @(posedge sh_clk);
    #1;
    sh_rst_n = 1'b1;
    out_rdy  = 1'b1;
    clear_log();
    n = 0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      if (out_vld) n++;
    end
    chk("midreset_quiet", 32'(n), 32'd0);
    load(0, 3, 32'h0000_0005, 1'b0);
    load(1, 8, 32'h0000_004D, 1'b0);
    chain_mask = 4'b0011;
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    wait_idle("redump_done", 200);
    chk("redump_nbytes", 32'(q_dat.size()), 32'd2);
    chk_byte(0, 8'h05, 1'b1, 2'd0);
    chk_byte(1, 8'h4D, 1'b1, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shadow_dump_ctrl.md
SHADOW_DUMP_CTRL -- requirements
Module: shadow_dump_ctrl

Interface
REQ-001 SHALL have parameter NUM_CHAINS, default 4, number of shadow capture chains served.
REQ-002 SHALL have parameter TIMEOUT, default 255, idle cycles tolerated per chain during dump.
REQ-003 SHALL have port sh_clk  in  1  shadow/data clock; the single clock, all state on its rising edge.
REQ-004 SHALL have port sh_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port arm  in  1  pulse: start capturing (enter CAPTURE).
REQ-006 SHALL have port freeze  in  1  pulse: stop capture, begin dump sequence.
REQ-007 SHALL have port chain_mask  in  NUM_CHAINS  1 = chain included in dump; sampled on freeze.
REQ-008 SHALL have port c_en  out  1  capture enable to all chains.
REQ-009 SHALL have port dump_en  out  NUM_CHAINS  one-hot dump enable; low pauses the selected chain.
REQ-010 SHALL have port ch_out  in  NUM_CHAINS  serial chain data.
REQ-011 SHALL have port ch_out_vld  in  NUM_CHAINS  ch_out bit valid this cycle.
REQ-012 SHALL have port ch_out_done  in  NUM_CHAINS  chain has emitted its last bit.
REQ-013 SHALL have port out_data  out  8  packed dump byte, first chain bit in bit 0.
REQ-014 SHALL have port out_vld / out_rdy  out / in  1 each  byte handshake; transfer when both high.
REQ-015 SHALL have port out_last  out  1  byte is last of current chain.
REQ-016 SHALL have port out_chain  out  clog2(NUM_CHAINS)  chain index of out_data.
REQ-017 SHALL have ports busy, err  out  1 each  sequence active; sticky timeout flag, cleared on arm.

Function
REQ-018 SHALL implement states IDLE, CAPTURE, SELECT, DUMP, FLUSH, DONE.
REQ-019 IDLE: arm -> CAPTURE; freeze ignored.
REQ-020 CAPTURE: c_en=1; freeze -> SELECT next cycle with c_en=0; arm and freeze same cycle in IDLE -> CAPTURE only.
REQ-021 SELECT: pick lowest unmasked index above last dumped chain; none left -> DONE; zero-mask -> DONE directly.
REQ-022 DUMP: dump_en[sel]=1 while byte buffer has room; each vld bit shifts into buffer at next bit position.
REQ-023 Eighth bit completes a byte: out_vld=1 next cycle; dump_en[sel]=0 until out_rdy transfers it (no bit loss under backpressure).
REQ-024 ch_out_done on sel -> FLUSH; bit with done in same cycle is captured first.
REQ-025 FLUSH: emit remaining partial byte zero-padded above last bit, out_last=1; if byte exactly complete, that byte carries out_last=1; chain with zero bits emits one 0x00 byte with out_last=1.
REQ-026 Timeout: TIMEOUT consecutive DUMP cycles with dump_en high and no vld/done -> err=1, FLUSH, continue with next chain.
REQ-027 out_data/out_last/out_chain SHALL stay stable while out_vld=1 and out_rdy=0.
REQ-028 DONE: one cycle, busy=0 afterwards, return to IDLE.
REQ-029 busy=1 in all states except IDLE; arm outside IDLE ignored.
REQ-030 vld/done from non-selected chains SHALL be ignored.

Reset
REQ-031 sh_rst_n low SHALL immediately force IDLE, c_en=0, dump_en=0, out_vld=0, out_data=0, out_last=0, out_chain=0, busy=0, err=0, buffer and counters cleared.
REQ-032 Reset mid-dump SHALL abandon the in-flight byte; no out_vld until next arm/freeze.

Structure
REQ-033 State encoding and byte width constant SHALL live in shared package shadow_pkg.
REQ-034 Bit packer (shift register, bit count, full/last flags) SHALL be sub-module shadow_byte_packer.

Verification
REQ-035 Mask 4'b1111, chain bit counts 3,8,10,0, out_rdy=1 -> bytes: ch0 1 (last), ch1 1 (last), ch2 2 (2nd last, 2 bits), ch3 0x00 (last).
REQ-036 Chain1 bits 1,0,1,1,0,0,1,0 -> out_data=0x4D, out_chain=1, out_last=1.
REQ-037 out_rdy low 20 cycles after first byte of 24-bit chain -> dump_en low those cycles, all 3 bytes delivered intact.
REQ-038 Mask 4'b0101, chain 2 silent -> err=1 after 255 cycles, ch2 byte with out_last, DONE, busy=0.
REQ-039 sh_rst_n low mid-DUMP -> all outputs 0 same cycle, arm then freeze re-dumps from chain 0.
REQ-040 arm and freeze same cycle in IDLE -> CAPTURE, c_en=1, no dump until later freeze.
